muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter: WIDTH, default 16, operand width; all behaviour below is stated for WIDTH=16.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  request new operation; sampled only in IDLE.
REQ-005 Port: op  input  1  0 = unsigned multiply, 1 = unsigned divide; sampled with start.
REQ-006 Port: a  input  16  multiplicand / dividend; sampled with start.
REQ-007 Port: b  input  16  multiplier / divisor; sampled with start.
REQ-008 Port: busy  output  1  high while an operation is iterating.
REQ-009 Port: done  output  1  one-cycle pulse, results valid.
REQ-010 Port: hi  output  16  multiply: product[31:16]; divide: remainder.
REQ-011 Port: lo  output  16  multiply: product[15:0]; divide: quotient.
REQ-012 Port: dz  output  1  divide-by-zero flag for the last completed operation.

Function
REQ-013 States: IDLE, RUN; 5-bit iteration counter; operands, op and the 32-bit {hi,lo} accumulator are registered.
REQ-014 IDLE with start=1 and not (op=1 and b=0): latch a, b, op; clear counter; go to RUN; busy=1 from the next cycle.
REQ-015 RUN runs exactly 16 iterations, one per clock; after the 16th edge: state IDLE, busy=0, done=1 for one cycle.
REQ-016 Latency: done is high in the 16th cycle after the start-sampling edge; hi/lo are valid in that cycle and are held until the next accepted start or rst.
REQ-017 Multiply iteration (shift-add): if multiplier LSB=1, add the multiplicand to hi using a 17-bit sum with carry out; then shift {carry,hi,lo} right by 1; lo is initialised to b and hi to 0.
REQ-018 Divide iteration (restoring): shift {rem,quo} left 1; trial = rem - divisor, computed as rem + ~divisor + 1 (two's complement, carry-in 1); carry out 1 means no borrow, so rem := trial and quotient bit 1; otherwise rem unchanged and quotient bit 0.
REQ-019 The add/subtract path is a single shared 17-bit adder; invert B and carry-in are both driven by op; no second adder is used.
REQ-020 Divide by zero (start, op=1, b=0, in IDLE): no RUN; next cycle done=1, dz=1, lo=16'hFFFF, hi=a; busy stays 0.
REQ-021 dz is cleared on any accepted start of a non-zero-divisor operation; it is otherwise held.
REQ-022 start while busy=1 is ignored; latched operands are not disturbed.
REQ-023 start in the cycle where done=1 is accepted, because the state is already IDLE; the new operation then proceeds normally.
REQ-024 hi/lo hold intermediate accumulator values during RUN; consumers use them only when done=1.
REQ-025 op, a and b changes while not sampled have no effect.

Reset
REQ-026 rst=1 at a clock edge: state IDLE, counter 0, busy=0, done=0, dz=0, hi=0, lo=0.
REQ-027 rst during RUN aborts the operation; done is not asserted for the aborted operation.
REQ-028 rst takes priority over start in the same cycle.

Verification
REQ-029 Multiply: start, op=0, a=16'hFFFF, b=16'hFFFF -> done exactly 16 cycles later; hi=16'hFFFE, lo=16'h0001, dz=0.
REQ-030 Divide: op=1, a=100, b=7 -> after 16 cycles, lo=14, hi=2, dz=0; a=16'hFFFF, b=1 -> lo=16'hFFFF, hi=0.
REQ-031 Divide by zero: op=1, a=16'h1234, b=0 -> done next cycle, dz=1, lo=16'hFFFF, hi=16'h1234, busy never high.
REQ-032 Start while busy: start mul 3*5; at cycle 5 pulse start with div 9/3 -> done once, hi=0, lo=15, no second done.
REQ-033 Reset mid-run: mul 16'h1234*16'h0010; rst at cycle 8 -> busy=0, hi=lo=0, no done; a fresh 2*3 then yields lo=6.
REQ-034 Back-to-back: start held high continuously with op=0, a=2, b=3 -> done every 17 cycles, each with lo=6, hi=0.

Source files
------------

// File: rtl/muldiv_seq.sv
// Sequential unsigned multiplier / restoring divider sharing one adder.
// Multiply: shift-add over WIDTH cycles. Divide: restoring, WIDTH cycles.
// Divide by zero bypasses iteration and reports through dz.
module muldiv_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  localparam int unsigned CW = 5;
  localparam int unsigned AW = 2 * WIDTH;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [AW-1:0]    r_acc;
  logic             r_busy;
  logic             r_done;
  logic             r_dz;

  logic [WIDTH-1:0] w_rem_sh;
  logic [WIDTH-1:0] w_add_a;
  logic [WIDTH-1:0] w_add_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_mul_hi;
  logic             w_no_borrow;
  logic [AW-1:0]    w_mul_next;
  logic [AW-1:0]    w_div_next;

  // Shared adder: divide subtracts the divisor from the shifted remainder,
  // multiply adds the multiplicand to the upper half.
  always_comb begin
    w_rem_sh    = r_acc[AW-2:WIDTH-1];
    w_add_a     = r_op ? w_rem_sh : r_acc[AW-1:WIDTH];
    w_add_b     = r_op ? ~r_b : r_a;
    w_sum       = {1'b0, w_add_a} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, r_op};
    // Bit shifted out of the remainder means it already exceeds any divisor.
    w_no_borrow = r_acc[AW-1] | w_sum[WIDTH];
    w_mul_hi    = r_acc[0] ? w_sum : {1'b0, r_acc[AW-1:WIDTH]};
    w_mul_next  = {w_mul_hi, r_acc[WIDTH-1:1]};
    w_div_next  = w_no_borrow ? {w_sum[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                              : {w_rem_sh,         r_acc[WIDTH-2:0], 1'b0};
  end

  // Control FSM, operand latches and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (op && (b == '0)) begin
              r_done <= 1'b1;
              r_dz   <= 1'b1;
              r_acc  <= {a, {WIDTH{1'b1}}};
            end else begin
              r_a     <= a;
              r_b     <= b;
              r_op    <= op;
              r_cnt   <= '0;
              r_dz    <= 1'b0;
              r_busy  <= 1'b1;
              r_acc   <= op ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_acc <= r_op ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign dz   = r_dz;
  assign hi   = r_acc[AW-1:WIDTH];
  assign lo   = r_acc[WIDTH-1:0];

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed scenarios with literal results plus
// randomized traffic checked every cycle against an arithmetic model.
module tb_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] hi;
  logic [15:0] lo;
  logic        dz;

  int tests = 0;
  int fails = 0;

  muldiv_seq #(.WIDTH(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo),
    .dz   (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: result computed with plain arithmetic, delivered
  // 16 edges after acceptance.
  logic        m_init  = 1'b0;
  logic        m_busy  = 1'b0;
  logic        m_done  = 1'b0;
  logic        m_dz    = 1'b0;
  logic        m_valid = 1'b0;
  logic [15:0] m_hi    = '0;
  logic [15:0] m_lo    = '0;
  logic [15:0] p_hi    = '0;
  logic [15:0] p_lo    = '0;
  int          m_rem   = 0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_init = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
      m_hi = '0; m_lo = '0; m_valid = 1'b1; m_rem = 0;
    end else if (m_init) begin
      m_done = 1'b0;
      if (m_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 1'b0; m_done = 1'b1; m_hi = p_hi; m_lo = p_lo; m_valid = 1'b1;
        end
      end else if (start) begin
        if (op && b == 16'd0) begin
          m_done = 1'b1; m_dz = 1'b1; m_hi = a; m_lo = 16'hFFFF; m_valid = 1'b1;
        end else begin
          logic [31:0] prod;
          m_busy = 1'b1; m_rem = 16; m_dz = 1'b0; m_valid = 1'b0;
          if (op) begin
            p_lo = a / b;
            p_hi = a % b;
          end else begin
            prod = 32'(a) * 32'(b);
            p_hi = prod[31:16];
            p_lo = prod[15:0];
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (m_init) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("dz",   32'(dz),   32'(m_dz));
      if (m_valid) begin
        chk("hi", 32'(hi), 32'(m_hi));
        chk("lo", 32'(lo), 32'(m_lo));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one operation and wait (bounded) for done; lat counts edges after the start edge.
  task automatic run_op(input logic o, input logic [15:0] x, input logic [15:0] y,
                        output int lat, output logic [15:0] rh, output logic [15:0] rl,
                        output logic rdz, output logic rbusy);
    logic seen;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    lat = 0; seen = 1'b0; rh = '0; rl = '0; rdz = 1'b0; rbusy = busy;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1'b1; rh = hi; rl = lo; rdz = dz;
        break;
      end
      @(negedge clk);
      lat++;
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    int          lat;
    int          nd;
    int          last;
    logic [15:0] rh, rl;
    logic        rdz, rb;

    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    do_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz",   32'(dz),   32'd0);
    chk("rst_hi",   32'(hi),   32'd0);
    chk("rst_lo",   32'(lo),   32'd0);

    run_op(1'b0, 16'hFFFF, 16'hFFFF, lat, rh, rl, rdz, rb);
    chk("mul_lat", 32'(lat), 32'd16);
    chk("mul_hi",  32'(rh),  32'hFFFE);
    chk("mul_lo",  32'(rl),  32'h0001);
    chk("mul_dz",  32'(rdz), 32'd0);

    run_op(1'b1, 16'd100, 16'd7, lat, rh, rl, rdz, rb);
    chk("div_lat", 32'(lat), 32'd16);
    chk("div_lo",  32'(rl),  32'd14);
    chk("div_hi",  32'(rh),  32'd2);
    chk("div_dz",  32'(rdz), 32'd0);

    run_op(1'b1, 16'hFFFF, 16'd1, lat, rh, rl, rdz, rb);
    chk("div1_lo", 32'(rl), 32'hFFFF);
    chk("div1_hi", 32'(rh), 32'd0);

    run_op(1'b1, 16'h1234, 16'd0, lat, rh, rl, rdz, rb);
    chk("dz_lat",  32'(lat), 32'd0);
    chk("dz_flag", 32'(rdz), 32'd1);
    chk("dz_lo",   32'(rl),  32'hFFFF);
    chk("dz_hi",   32'(rh),  32'h1234);
    chk("dz_busy", 32'(rb),  32'd0);
    @(negedge clk);
    chk("dz_hold", 32'(dz), 32'd1);

    // Start pulse while busy must be ignored.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 16'd3; b = 16'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 1'b1; a = 16'd9; b = 16'd3;
    @(negedge clk);
    start = 1'b0;
    nd = 0; rh = '1; rl = '1;
    for (int i = 0; i < 40; i++) begin
      if (done) begin nd++; rh = hi; rl = lo; end
      @(negedge clk);
    end
    chk("busy_ign_ndone", 32'(nd), 32'd1);
    chk("busy_ign_hi",    32'(rh), 32'd0);
    chk("busy_ign_lo",    32'(rl), 32'd15);

    // Reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 16'h1234; b = 16'h0010;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi",   32'(hi),   32'd0);
    chk("abort_lo",   32'(lo),   32'd0);
    nd = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("abort_ndone", 32'(nd), 32'd0);
    run_op(1'b0, 16'd2, 16'd3, lat, rh, rl, rdz, rb);
    chk("after_abort_lo", 32'(rl), 32'd6);
    chk("after_abort_hi", 32'(rh), 32'd0);

    // start held high: a new operation every 17 cycles.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 16'd2; b = 16'd3;
    nd = 0; last = -1;
    for (int i = 0; i < 81; i++) begin
      @(negedge clk);
      if (done) begin
        if (last < 0) chk("b2b_first", 32'(i), 32'd16);
        else          chk("b2b_period", 32'(i - last), 32'd17);
        chk("b2b_lo", 32'(lo), 32'd6);
        chk("b2b_hi", 32'(hi), 32'd0);
        last = i;
        nd++;
      end
    end
    start = 1'b0;
    chk("b2b_ndone", 32'(nd), 32'd4);
    repeat (20) @(negedge clk);

    // Randomized traffic, including starts while busy, input wiggle and rare resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      op    = 1'($urandom);
      a     = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 16'd0;
        1, 2:    b = 16'($urandom_range(1, 255));
        default: b = 16'($urandom);
      endcase
      rst   = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
